// File: rtl/mem_port_master.sv
// mem_port_master: fetch/LSU arbiter and initiator for the unified memory port.
// Ports: clk, rst (async active-low), if_* fetch side, d_* data side, mem_* memory side.
module mem_port_master #(
  parameter int DATA_OFFSET = 200,
  parameter int RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [11:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic        if_err,
  output logic [31:0] if_instr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_type,
  input  logic        d_sign,
  input  logic [11:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_sign,
  output logic [1:0]  mem_type,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [11:0] OFFSET   = 12'(DATA_OFFSET);
  localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);

  logic [1:0]  state;
  logic [1:0]  typ;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        sign;
  logic        we;
  logic        src;
  logic        err;
  logic [2:0]  cnt;
  logic        rr;

  logic idle;
  logic acc;
  logic both;
  logic f_bad;
  logic d_bad;

  assign idle = rst && (state == IDLE);
  assign acc  = (state == ACCESS);
  assign both = if_req && d_req;

  // rr = 0 favours fetch, rr = 1 favours data on contention
  assign if_gnt = idle && if_req && !(d_req && rr);
  assign d_gnt  = idle && d_req && !(if_req && !rr);

  // alignment is judged on the address the core issued, not the physical one
  assign f_bad = (if_addr[1:0] != 2'b00);

  always_comb begin
    d_bad = 1'b0;
    unique case (d_type)
      2'd0:    d_bad = 1'b0;
      2'd1:    d_bad = d_addr[0];
      2'd2:    d_bad = (d_addr[1:0] != 2'b00);
      default: d_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      typ      <= 2'd0;
      addr     <= 12'd0;
      wdata    <= 32'd0;
      sign     <= 1'b0;
      we       <= 1'b0;
      src      <= 1'b0;
      err      <= 1'b0;
      cnt      <= 3'd0;
      rr       <= 1'b0;
      if_instr <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_gnt || d_gnt) begin
            src <= d_gnt;
            cnt <= LAT_LAST;
            if (both) rr <= ~rr;
            if (d_gnt) begin
              typ   <= d_type;
              addr  <= d_addr + OFFSET;
              wdata <= d_wdata;
              sign  <= d_sign;
              we    <= d_we;
              err   <= d_bad;
              state <= d_bad ? RESP : ACCESS;
            end else begin
              typ   <= 2'd2;
              addr  <= if_addr;
              wdata <= 32'd0;
              sign  <= 1'b0;
              we    <= 1'b0;
              err   <= f_bad;
              state <= f_bad ? RESP : ACCESS;
            end
          end
        end
        ACCESS: begin
          if (we) begin
            state <= RESP;
          end else if (cnt == 3'd0) begin
            state <= RESP;
            if (src) d_rdata <= mem_rdata;
            else     if_instr <= mem_rdata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // strobes are decoded from state so an async reset drops them at once
  assign mem_read  = acc && !we;
  assign mem_write = acc && we;
  assign mem_sign  = acc && sign;
  assign mem_type  = acc ? typ : 2'd0;
  assign mem_addr  = acc ? addr : 12'd0;
  assign mem_wdata = (acc && we) ? wdata : 32'd0;

  assign if_valid = (state == RESP) && !src;
  assign d_valid  = (state == RESP) && src;
  assign if_err   = if_valid && err;
  assign d_err    = d_valid && err;

endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Initiator side of the unified byte-addressed instruction/data memory port.
- Arbitrates one instruction-fetch requester and one load/store requester onto the single memory port.
- Adds the data-region offset to data addresses, rejects misaligned or illegal accesses before they reach memory, and returns read data with a fixed-latency response handshake.
- Sits between the core's fetch/LSU logic and the memory block.

Parameters:
- DATA_OFFSET, 200, byte offset added to every data address (12-bit wrap); fetch addresses are not offset.
- RD_LAT, 1, cycles mem_read is held before mem_rdata is captured; legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until granted.
- if_addr  in  12  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_valid  out  1  one-cycle fetch response pulse.
- if_err  out  1  fetch misaligned; qualified by if_valid.
- if_instr  out  32  fetched word; held until the next fetch capture.
- d_req  in  1  data request, held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_type  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- d_sign  in  1  sign-extend a load.
- d_addr  in  12  data byte address, before offset.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_valid  out  1  one-cycle data response pulse.
- d_err  out  1  misaligned or illegal access; qualified by d_valid.
- d_rdata  out  32  load data; held until the next load capture.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_sign  out  1  to memory Sign.
- mem_type  out  2  to memory type.
- mem_addr  out  12  physical byte address.
- mem_wdata  out  32  store data to memory.
- mem_rdata  in  32  memory read data.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Registers: request type, addr, wdata, sign, we, src (fetch/data), err, latency counter (3 bits), round-robin pointer rr.
- Reset (rst low, async): state IDLE, rr = fetch-first, all outputs 0, including if_instr and d_rdata.
- Grants are given only in IDLE; at most one grant per cycle.
  - One requester active: that requester is granted.
  - Both active: the one named by rr is granted; rr then points to the other.
  - A granted request is registered on that rising edge.
- Error checks at grant, evaluated on the un-offset address:
  - Fetch error: if_addr[1:0] != 0.
  - Data error: d_type == 3, or half with addr[0] = 1, or word with addr[1:0] != 0.
  - Erroneous request: IDLE -> RESP directly. No mem strobe ever asserts. The response carries err = 1 and rdata is unchanged.
- Legal request: IDLE -> ACCESS.
  - mem_addr = fetch addr, or (d_addr + DATA_OFFSET) mod 4096.
  - Fetch drives mem_type = 2 and mem_sign = 0.
  - Load: mem_read = 1 for exactly RD_LAT cycles. On the rising edge ending the last cycle, mem_rdata is captured into if_instr or d_rdata. Then go to RESP.
  - Store: mem_write = 1 for exactly 1 cycle (independent of RD_LAT) and mem_wdata = d_wdata. Then go to RESP.
- RESP lasts 1 cycle: the selected if_valid or d_valid = 1, with the matching err. Then go to IDLE.
  - No grant is given in RESP, so there is one idle bubble between transactions.
- Latency from grant cycle to valid:
  - Legal load/fetch: RD_LAT + 1 cycles.
  - Store: 2 cycles.
  - Error: 1 cycle.
- Outside ACCESS: mem_read, mem_write, mem_type, mem_sign, mem_addr and mem_wdata are all 0.
- Request inputs are ignored after grant; changes during ACCESS have no effect.
- rst asserted mid-ACCESS: strobes drop immediately, no response is produced, and the pending transaction is discarded.

Test Plan:
- Fetch only, RD_LAT = 1, if_addr = 0x010, mem_rdata = 0x015A0663 → mem_read high 1 cycle with mem_addr = 0x010 and mem_type = 2; if_valid 2 cycles after grant; if_instr = 0x015A0663; if_err = 0.
- Store word, d_addr = 0x00C, d_wdata = 34 → mem_write high exactly 1 cycle with mem_addr = 212 (0x0D4), mem_wdata = 34, mem_type = 2; d_valid 2 cycles after grant; d_err = 0.
- Simultaneous if_req and d_req from reset → fetch granted first, data granted in the IDLE cycle after fetch RESP. Repeat with both held → grants alternate F, D, F, D.
- Misaligned: half at d_addr = 0x003, word at 0x002, and d_type = 3 → each gives d_valid 1 cycle after grant with d_err = 1, no mem strobe, d_rdata unchanged. Fetch at if_addr = 0x006 → if_err = 1.
- Wrap and latency: RD_LAT = 3, load byte at d_addr = 0xF80 with d_sign = 1 → mem_addr = 0x048, mem_read high 3 cycles, mem_sign = 1, mem_type = 0; d_valid 4 cycles after grant.
- Async reset asserted during the second ACCESS cycle → all outputs 0 immediately, no valid pulse; after release, a new fetch is granted fetch-first and completes normally.
